// File: rtl/win_load_scheduler_if.sv
// Frame-control, window-loader and core-side signals of the window load
// scheduler, bundled into one interface.
//   master : scheduler view (drives busy/frame_done, wl_start/addr/ack, win_*)
//   slave  : environment view (drives cfg_*, wl_ready, wl_done, buf_release)
interface win_load_scheduler_if #(
    parameter int Y_BITS     = 9,
    parameter int BLOCK_BITS = 6,
    parameter int WIN_BITS   = 8
);
    logic                  cfg_start;
    logic [WIN_BITS-1:0]   cfg_win_size;
    logic [Y_BITS-1:0]     cfg_max_y;
    logic [BLOCK_BITS-1:0] cfg_max_block;
    logic                  busy;
    logic                  frame_done;
    logic                  wl_start;
    logic [Y_BITS-1:0]     wl_start_y;
    logic [BLOCK_BITS-1:0] wl_start_block;
    logic [WIN_BITS-1:0]   wl_win_size;
    logic                  wl_dbl_buf;
    logic                  wl_ready;
    logic                  wl_done;
    logic                  wl_ack;
    logic                  win_valid;
    logic                  win_buf;
    logic [Y_BITS-1:0]     win_y;
    logic [BLOCK_BITS-1:0] win_block;
    logic [1:0]            buf_release;

    modport master (
        input  cfg_start, cfg_win_size, cfg_max_y, cfg_max_block,
        input  wl_ready, wl_done, buf_release,
        output busy, frame_done,
        output wl_start, wl_start_y, wl_start_block, wl_win_size, wl_dbl_buf, wl_ack,
        output win_valid, win_buf, win_y, win_block
    );

    modport slave (
        output cfg_start, cfg_win_size, cfg_max_y, cfg_max_block,
        output wl_ready, wl_done, buf_release,
        input  busy, frame_done,
        input  wl_start, wl_start_y, wl_start_block, wl_win_size, wl_dbl_buf, wl_ack,
        input  win_valid, win_buf, win_y, win_block
    );
endinterface

// File: rtl/win_load_scheduler.sv
// Window load scheduler: raster-scans every window start position of a frame,
// issues one load per position into the cores' double-buffered window caches
// and tracks buffer ownership against core release pulses.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset (abandons any frame in progress)
//   bus    : win_load_scheduler_if.master (config, loader handshake, window
//            notification, buffer release)
//
// state     | meaning
// ----------|---------------------------------------------------------
// IDLE      | waiting for a frame start with non-zero window size
// WAIT_BUF  | waiting for target buffer free and loader ready
// ISSUE     | wl_start pulse with the current position
// LOADING   | waiting for the loader to report done
// ACK       | wl_ack + win_valid pulse, buffer marked full
// ADVANCE   | step to the next raster position or finish the scan
// FLUSH     | all loads issued, waiting for both buffers to drain
// DONE      | frame_done pulse
module win_load_scheduler #(
    parameter int Y_BITS     = 9,
    parameter int BLOCK_BITS = 6,
    parameter int WIN_BITS   = 8
) (
    input logic                 clk,
    input logic                 resetn,
    win_load_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BUF, S_ISSUE, S_LOADING, S_ACK, S_ADVANCE, S_FLUSH, S_DONE
    } state_t;

    state_t                state_q;
    logic [1:0]            buf_full_q, buf_full_d, buf_set;
    logic                  wr_sel_q;
    logic [Y_BITS-1:0]     cur_y_q, max_y_q;
    logic [BLOCK_BITS-1:0] cur_block_q, max_block_q;
    logic [WIN_BITS-1:0]   win_size_q;

    logic                  busy_q, frame_done_q, wl_start_q, wl_dbl_buf_q, wl_ack_q;
    logic [Y_BITS-1:0]     wl_start_y_q, win_y_q;
    logic [BLOCK_BITS-1:0] wl_start_block_q, win_block_q;
    logic [WIN_BITS-1:0]   wl_win_size_q;
    logic                  win_valid_q, win_buf_q;

    // The set lands on the edge that enters ACK; a release on the same buffer
    // in that edge loses to the set.
    always_comb begin
        buf_set = 2'b00;
        if (state_q == S_LOADING && bus.wl_done) begin
            buf_set = {wr_sel_q, ~wr_sel_q};
        end
        buf_full_d = (buf_full_q & ~bus.buf_release) | buf_set;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= S_IDLE;
            buf_full_q       <= 2'b00;
            wr_sel_q         <= 1'b0;
            cur_y_q          <= '0;
            cur_block_q      <= '0;
            max_y_q          <= '0;
            max_block_q      <= '0;
            win_size_q       <= '0;
            busy_q           <= 1'b0;
            frame_done_q     <= 1'b0;
            wl_start_q       <= 1'b0;
            wl_start_y_q     <= '0;
            wl_start_block_q <= '0;
            wl_win_size_q    <= '0;
            wl_dbl_buf_q     <= 1'b0;
            wl_ack_q         <= 1'b0;
            win_valid_q      <= 1'b0;
            win_buf_q        <= 1'b0;
            win_y_q          <= '0;
            win_block_q      <= '0;
        end else begin
            buf_full_q   <= buf_full_d;
            wl_start_q   <= 1'b0;
            wl_ack_q     <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cfg_start && bus.cfg_win_size != '0) begin
                        win_size_q  <= bus.cfg_win_size;
                        max_y_q     <= bus.cfg_max_y;
                        max_block_q <= bus.cfg_max_block;
                        cur_y_q     <= '0;
                        cur_block_q <= '0;
                        wr_sel_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_WAIT_BUF;
                    end
                end
                S_WAIT_BUF: begin
                    if (!buf_full_q[wr_sel_q] && bus.wl_ready) begin
                        wl_start_q       <= 1'b1;
                        wl_start_y_q     <= cur_y_q;
                        wl_start_block_q <= cur_block_q;
                        wl_win_size_q    <= win_size_q;
                        wl_dbl_buf_q     <= wr_sel_q;
                        state_q          <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_LOADING;
                S_LOADING: begin
                    if (bus.wl_done) begin
                        wl_ack_q    <= 1'b1;
                        win_valid_q <= 1'b1;
                        win_buf_q   <= wr_sel_q;
                        win_y_q     <= cur_y_q;
                        win_block_q <= cur_block_q;
                        wr_sel_q    <= ~wr_sel_q;
                        state_q     <= S_ACK;
                    end
                end
                S_ACK: state_q <= S_ADVANCE;
                S_ADVANCE: begin
                    if (cur_y_q == max_y_q && cur_block_q == max_block_q) begin
                        state_q <= S_FLUSH;
                    end else begin
                        if (cur_block_q == max_block_q) begin
                            cur_block_q <= '0;
                            cur_y_q     <= cur_y_q + 1'b1;
                        end else begin
                            cur_block_q <= cur_block_q + 1'b1;
                        end
                        state_q <= S_WAIT_BUF;
                    end
                end
                S_FLUSH: begin
                    if (buf_full_q == 2'b00) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.wl_start       = wl_start_q;
    assign bus.wl_start_y     = wl_start_y_q;
    assign bus.wl_start_block = wl_start_block_q;
    assign bus.wl_win_size    = wl_win_size_q;
    assign bus.wl_dbl_buf     = wl_dbl_buf_q;
    assign bus.wl_ack         = wl_ack_q;
    assign bus.win_valid      = win_valid_q;
    assign bus.win_buf        = win_buf_q;
    assign bus.win_y          = win_y_q;
    assign bus.win_block      = win_block_q;

endmodule

// File: tb/tb_win_load_scheduler.sv
// Self-checking bench for win_load_scheduler: table of frame configurations
// with hand-computed load counts and drain gaps, plus directed sequences for
// backpressure, loader-not-ready, ignored starts and mid-frame reset.
module tb_win_load_scheduler;

    logic clk;
    logic resetn;

    win_load_scheduler_if #(.Y_BITS(9), .BLOCK_BITS(6), .WIN_BITS(8)) bus ();

    win_load_scheduler #(.Y_BITS(9), .BLOCK_BITS(6), .WIN_BITS(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int my;
        int mb;
        int sz;
        int rd;
        int exp_loads;
        int exp_gap;
    } vec_t;

    vec_t vecs[4];

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int rel_delay;
    int rel_cnt[2];
    int ld_cnt;
    int ld_lat = 2;
    bit ld_busy;
    bit ready_en = 1'b1;
    int done_rise;
    int start_cyc;
    int n_iss, n_win, n_ack, misalign, done_cnt, done_cyc, last_rel_cyc;

    logic [8:0] iss_y[64];
    logic [5:0] iss_b[64];
    logic       iss_dbl[64];
    logic [7:0] iss_sz[64];
    int         iss_cyc[64];
    logic [8:0] wv_y[64];
    logic [5:0] wv_b[64];
    logic       wv_buf[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        n_iss = 0; n_win = 0; n_ack = 0; misalign = 0;
        done_cnt = 0; done_cyc = -1; last_rel_cyc = -1; done_rise = -100;
        rel_cnt[0] = -1; rel_cnt[1] = -1;
    endtask

    // One cycle of environment: sample DUT at the falling edge, run the loader
    // and core models, drive the next inputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        bus.buf_release = 2'b00;
        bus.cfg_start   = 1'b0;
        if (bus.wl_start) begin
            if (n_iss < 64) begin
                iss_y[n_iss]   = bus.wl_start_y;
                iss_b[n_iss]   = bus.wl_start_block;
                iss_dbl[n_iss] = bus.wl_dbl_buf;
                iss_sz[n_iss]  = bus.wl_win_size;
                iss_cyc[n_iss] = cyc;
            end
            n_iss++;
            ld_busy = 1'b1;
            ld_cnt  = ld_lat;
        end else if (ld_cnt > 0) begin
            ld_cnt--;
            if (ld_cnt == 0) begin
                bus.wl_done = 1'b1;
                done_rise   = cyc;
            end
        end
        if (bus.wl_ack) begin
            bus.wl_done = 1'b0;
            ld_busy     = 1'b0;
            n_ack++;
            if (!bus.win_valid) misalign++;
            if (cyc != done_rise + 1) misalign++;
        end
        if (bus.win_valid) begin
            if (n_win < 64) begin
                wv_y[n_win]   = bus.win_y;
                wv_b[n_win]   = bus.win_block;
                wv_buf[n_win] = bus.win_buf;
            end
            n_win++;
            if (!bus.wl_ack) misalign++;
            if (rel_delay >= 0) rel_cnt[bus.win_buf] = rel_delay;
        end
        for (int b = 0; b < 2; b++) begin
            if (rel_cnt[b] == 0) begin
                bus.buf_release[b] = 1'b1;
                rel_cnt[b]         = -1;
                last_rel_cyc       = cyc;
            end else if (rel_cnt[b] > 0) begin
                rel_cnt[b]--;
            end
        end
        if (bus.frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        bus.wl_ready = ready_en && !ld_busy;
    endtask

    task automatic begin_frame(input int my, input int mb, input int sz, input int rd);
        clear_rec();
        rel_delay = rd;
        step();
        bus.cfg_max_y     = 9'(my);
        bus.cfg_max_block = 6'(mb);
        bus.cfg_win_size  = 8'(sz);
        bus.cfg_start     = 1'b1;
        start_cyc         = cyc;
    endtask

    task automatic wait_done(input int inj, input int budget);
        bit injd = 1'b0;
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            step();
            if (inj != 0 && !injd && n_iss == 1) begin
                injd              = 1'b1;
                bus.cfg_start     = 1'b1;
                bus.cfg_win_size  = 8'd99;
                bus.cfg_max_y     = 9'd3;
                bus.cfg_max_block = 6'd3;
            end
        end
        check("frame_done_seen", 64'(done_cnt), 64'd1);
        step();
        step();
    endtask

    task automatic check_loads(input string tag, input int mb, input int sz, input int cnt);
        logic [23:0] exp_l, act_l;
        logic [15:0] exp_w, act_w;
        for (int i = 0; i < cnt && i < n_iss && i < 64; i++) begin
            act_l = {iss_y[i], iss_b[i], iss_dbl[i], iss_sz[i]};
            exp_l = {9'(i / (mb + 1)), 6'(i % (mb + 1)), 1'(i % 2), 8'(sz)};
            check({tag, "_load"}, 64'(act_l), 64'(exp_l));
        end
        for (int i = 0; i < cnt && i < n_win && i < 64; i++) begin
            act_w = {wv_y[i], wv_b[i], wv_buf[i]};
            exp_w = {9'(i / (mb + 1)), 6'(i % (mb + 1)), 1'(i % 2)};
            check({tag, "_win"}, 64'(act_w), 64'(exp_w));
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.busy, bus.frame_done, bus.wl_start, bus.wl_start_y, bus.wl_start_block,
                bus.wl_win_size, bus.wl_dbl_buf, bus.wl_ack, bus.win_valid, bus.win_buf,
                bus.win_y, bus.win_block};
    endfunction

    initial begin
        vecs[0] = '{my: 0, mb: 0, sz: 24, rd: 5, exp_loads: 1, exp_gap: 2};
        vecs[1] = '{my: 1, mb: 2, sz: 16, rd: 0, exp_loads: 6, exp_gap: 3};
        vecs[2] = '{my: 2, mb: 0, sz: 8,  rd: 1, exp_loads: 3, exp_gap: 2};
        vecs[3] = '{my: 0, mb: 3, sz: 40, rd: 3, exp_loads: 4, exp_gap: 2};

        bus.cfg_start = 1'b0; bus.cfg_win_size = '0; bus.cfg_max_y = '0; bus.cfg_max_block = '0;
        bus.wl_ready = 1'b1; bus.wl_done = 1'b0; bus.buf_release = 2'b00;
        ld_busy = 1'b0; ld_cnt = 0; rel_delay = -1;
        clear_rec();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        resetn = 1'b1;
        step();
        check("idle_outputs", all_outs(), 64'd0);

        // table-driven frames
        for (int v = 0; v < 4; v++) begin
            begin_frame(vecs[v].my, vecs[v].mb, vecs[v].sz, vecs[v].rd);
            wait_done(0, 400);
            check("n_loads", 64'(n_iss), 64'(vecs[v].exp_loads));
            check("n_win", 64'(n_win), 64'(vecs[v].exp_loads));
            check("n_ack", 64'(n_ack), 64'(vecs[v].exp_loads));
            check("ack_align", 64'(misalign), 64'd0);
            check("first_start_lat", 64'(iss_cyc[0] - start_cyc), 64'd2);
            check("done_gap", 64'(done_cyc - last_rel_cyc), 64'(vecs[v].exp_gap));
            check("busy_after", 64'(bus.busy), 64'd0);
            check_loads("vec", vecs[v].mb, vecs[v].sz, vecs[v].exp_loads);
        end

        // size 0 start is ignored
        clear_rec();
        step();
        bus.cfg_win_size = 8'd0; bus.cfg_start = 1'b1;
        step();
        check("zero_size_busy", 64'(bus.busy), 64'd0);
        repeat (5) step();
        check("zero_size_loads", 64'(n_iss), 64'd0);

        // loader not ready for 10 cycles after start
        ready_en = 1'b0;
        begin_frame(0, 0, 32, 0);
        bus.wl_ready = 1'b0;
        repeat (10) step();
        check("notready_withheld", 64'(n_iss), 64'd0);
        check("notready_busy", 64'(bus.busy), 64'd1);
        ready_en = 1'b1; bus.wl_ready = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < 10 && n_iss == 0; i++) step();
        check("notready_issue_lat", 64'(iss_cyc[0] - start_cyc), 64'd1);
        wait_done(0, 100);

        // start mid-frame leaves latched config untouched
        begin_frame(0, 1, 24, 0);
        wait_done(1, 200);
        check("midstart_loads", 64'(n_iss), 64'd2);
        check_loads("midstart", 1, 24, 2);

        // backpressure: cores never release
        ld_lat = 6;
        begin_frame(1, 2, 16, -1);
        repeat (40) step();
        check("bp_loads", 64'(n_iss), 64'd2);
        check("bp_busy", 64'(bus.busy), 64'd1);
        bus.buf_release = 2'b01;
        for (int i = 0; i < 20 && n_iss < 3; i++) step();
        check("bp_third", 64'(n_iss), 64'd3);
        check_loads("bp", 2, 16, 3);

        // reset while LOADING the third window
        step();
        resetn = 1'b0;
        #1;
        check("midreset_outputs", all_outs(), 64'd0);
        bus.wl_done = 1'b0; ld_busy = 1'b0; ld_cnt = 0;
        rel_cnt[0] = -1; rel_cnt[1] = -1;
        repeat (3) step();
        check("midreset_no_done", 64'(done_cnt), 64'd0);
        resetn = 1'b1;
        ld_lat = 2;
        begin_frame(0, 1, 20, 1);
        wait_done(0, 200);
        check("restart_loads", 64'(n_iss), 64'd2);
        check("restart_lat", 64'(iss_cyc[0] - start_cyc), 64'd2);
        check_loads("restart", 1, 20, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
